// File: rtl/multicycle_control.sv
// Multicycle RV32I control unit for lw, sw, R-type, I-type ALU, beq and jal.
// This is a Moore FSM that drives the datapath selects, the write enables,
// imm_src and alu_control.
// Optional build macro CTRL_BNE_EN adds bne handling in the branch state.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic [1:0] imm_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic [2:0] alu_control,
    output logic [3:0] state,
    output logic       instr_done
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_e;

    state_e     state_q;
    state_e     state_d;
    state_e     cur_s;
    aluop_e     aluop;
    logic       op_legal;
    logic       pc_update;
    logic       branch;
    logic       branch_taken;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       mem_write_raw;
    logic       done_raw;

    // Outputs show the FETCH decode while reset is asserted
    assign cur_s = reset ? S_FETCH : state_q;
    assign state = 4'(cur_s);

    assign op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                      (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore datapath controls per state
    always_comb begin
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        result_src    = 2'b00;
        adr_src       = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        done_raw      = 1'b0;
        aluop         = ALUOP_ADD;
        case (cur_s)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                pc_update    = 1'b1;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                done_raw  = ~op_legal;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src    = 2'b01;
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                aluop     = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                aluop     = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                done_raw      = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                aluop     = ALUOP_SUB;
                branch    = 1'b1;
                done_raw  = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            default: begin
                alu_src_a = 2'b00;
            end
        endcase
    end

    // Branch condition from the ALU zero flag
`ifdef CTRL_BNE_EN
    always_comb begin
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = ~zero;
            default: branch_taken = 1'b0;
        endcase
    end
`else
    assign branch_taken = zero;
`endif

    // ALU operation decode
    always_comb begin
        alu_control = 3'b000;
        case (aluop)
            ALUOP_SUB: alu_control = 3'b001;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    // Immediate format depends only on the opcode
    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    assign ir_write   = ir_write_raw  & ~reset;
    assign reg_write  = reg_write_raw & ~reset;
    assign mem_write  = mem_write_raw & ~reset;
    assign pc_write   = (pc_update | (branch & branch_taken)) & ~reset;
    assign instr_done = done_raw & ~reset;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control unit for the multicycle RV32I subset core (lw, sw, R-type, I-type ALU, beq, jal).
- A Moore FSM sequences every instruction through fetch, decode and execute steps, and drives the datapath mux selects and write enables.
- Configures the immediate sign-extender through imm_src, using the extender's 2-bit format encoding.
- Also produces the 3-bit ALU operation code.

Parameters:
- None. Widths are fixed by the RV32I datapath.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- imm_src  out  2  sign-extender format: 00 I, 01 S, 10 B, 11 J
- alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1 data
- alu_src_b  out  2  00 rs2 data, 01 immExt, 10 constant 4
- result_src  out  2  00 ALUOut, 01 memory data, 10 ALU result
- adr_src  out  1  0 PC, 1 result
- ir_write  out  1  instruction register load
- pc_write  out  1  PC load
- reg_write  out  1  register file write
- mem_write  out  1  data memory write
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- state  out  4  current FSM state (debug)
- instr_done  out  1  high in the final cycle of each instruction

Behaviour:
- Clocking: one clk; reset is synchronous, active-high.
- Reset: reset high at a rising edge sets state to FETCH (0).
  - While reset is high, ir_write, pc_write, reg_write, mem_write and instr_done are forced to 0 combinationally.
  - Every other output shows its FETCH value while reset is high.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10. Codes 11–15 go to FETCH on the next edge and drive all-zero outputs.
- Transitions:
  - FETCH→DECODE.
  - DECODE: op 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BEQ; 1101111 → JAL; any other op → FETCH with instr_done=1 (illegal instruction, no writes).
  - MEMADR: lw → MEMREAD, sw → MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECR and EXECI→ALUWB→FETCH.
  - BEQ→FETCH.
  - JAL→ALUWB.
- Latency: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; beq 3 cycles.
- Moore outputs per state (unlisted signals are 0):
  - FETCH: adr_src=0, ir_write=1, src_a=00, src_b=10, aluop=add, result_src=10, pc_update=1.
  - DECODE: src_a=01, src_b=01, aluop=add. Precomputes the branch/jump target.
  - MEMADR: src_a=10, src_b=01, aluop=add.
  - MEMREAD: result_src=00, adr_src=1.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: result_src=00, adr_src=1, mem_write=1.
  - EXECR: src_a=10, src_b=00, aluop=funct.
  - EXECI: src_a=10, src_b=01, aluop=funct.
  - ALUWB: result_src=00, reg_write=1.
  - BEQ: src_a=10, src_b=00, aluop=sub, result_src=00, branch=1.
  - JAL: src_a=01, src_b=10, aluop=add, result_src=00, pc_update=1.
- pc_write = pc_update | (branch & branch_taken); branch_taken = zero.
- instr_done = 1 in MEMWB, MEMWRITE, ALUWB, BEQ, and in DECODE when op is illegal.
- imm_src (combinational from op, valid in every state): 0100011→01, 1100011→10, 1101111→11, all other op→00.
- alu_control when aluop=funct, decoded from funct3:
  - 000: sub if op[5]&funct7b5, else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - any other funct3: add.
- Opcode changes outside DECODE/MEMADR do not alter the sequence; the instruction register is held by ir_write=0.

Optional Feature:
- Macro CTRL_BNE_EN.
- Defined: in BEQ, branch_taken = zero when funct3=000 and ~zero when funct3=001; other funct3 values give branch_taken=0.
- Undefined: branch_taken = zero for every funct3 (the whole branch opcode is treated as beq).

Test Plan:
- Reset: hold reset 2 cycles with op=0000011 → state=0, pc_write=0, ir_write=0. First cycle after release: ir_write=1, pc_write=1, alu_src_b=10.
- lw (op=0000011): state sequence 0,1,2,3,4,0. imm_src=00; reg_write=1 only in state 4; result_src=01 in state 4; instr_done pulses once.
- sw (op=0100011): states 0,1,2,5,0. imm_src=01; mem_write=1 only in state 5; reg_write never 1.
- R-type sub (op=0110011, funct3=000, funct7b5=1) → alu_control=001 in state 6. Same fields with op=0010011 → 000 (addi) in state 7. Then reg_write=1 in state 8.
- beq (op=1100011, funct3=000): imm_src=10. zero=1 → pc_write=1 in state 9; zero=0 → pc_write=0. Each takes 3 cycles. With CTRL_BNE_EN, funct3=001 inverts this.
- jal (op=1101111): states 0,1,10,8,0. imm_src=11; pc_write=1 in state 10. Illegal op=1111111 → 0,1,0 with instr_done=1 in state 1 and no write enables asserted.
